// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU op codes, arbiter states
// and default datapath widths.
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 4;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way combinational round-robin grant. A lone valid requester always
// wins; when both are valid the one that did not win last time is chosen.
module rr_arb2
  import alu_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // one-hot grant, zero when nobody is requesting
  always_comb begin
    gnt = 2'b00;
    case (req_valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters.
//
// state | meaning
// IDLE  | waiting for a request; round-robin grant offered via req_ready
// EXEC  | ALU driven from latched op/operands; result captured at the edge
// RESP  | captured result offered to the owner until it accepts
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int N_REQ  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_result,
  output logic                    rsp_zero,
  output logic [OP_W-1:0]         alu_operation,
  output logic [DATA_W-1:0]       alu_data_a,
  output logic [DATA_W-1:0]       alu_data_b,
  input  logic [DATA_W-1:0]       alu_result,
  input  logic                    alu_zero
);

  if (N_REQ != 2) begin : g_bad_n_req
    $error("alu_arbiter supports exactly two requesters");
  end

  arb_state_t        state, state_d;
  logic              last_grant;
  logic              owner;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [1:0]        gnt;
  logic              gnt_idx;
  logic              accept;
  logic              rsp_done;

  rr_arb2 u_rr_arb2 (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign gnt_idx = gnt[1];

  // ALU inputs come straight from the operand registers so they only move
  // when a new request is latched
  assign alu_operation = op_q;
  assign alu_data_a    = a_q;
  assign alu_data_b    = b_q;

  // next-state and handshake outputs
  always_comb begin
    state_d   = state;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = gnt;
        if (gnt != 2'b00) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // keep handshakes quiet while reset is held
    if (!rst_n) begin
      req_ready = '0;
      rsp_valid = '0;
      accept    = 1'b0;
      rsp_done  = 1'b0;
    end
  end

  // state, operand latch, result capture and round-robin history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        owner <= gnt_idx;
        if (gnt_idx) begin
          op_q <= req_op[OP_W +: OP_W];
          a_q  <= req_a[DATA_W +: DATA_W];
          b_q  <= req_b[DATA_W +: DATA_W];
        end else begin
          op_q <= req_op[0 +: OP_W];
          a_q  <= req_a[0 +: DATA_W];
          b_q  <= req_b[0 +: DATA_W];
        end
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
      end
      if (rsp_done) last_grant <= owner;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the external ALU.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a, req_b;
  logic [31:0] rsp_result, alu_data_a, alu_data_b, alu_result;
  logic        rsp_zero, alu_zero;
  logic [3:0]  alu_operation;

  int n_cmp = 0;
  int n_fail = 0;
  int last_served = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_operation(alu_operation), .alu_data_a(alu_data_a), .alu_data_b(alu_data_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // external ALU model; unknown codes default to add
  always_comb begin
    case (alu_operation)
      OP_AND:  alu_result = alu_data_a & alu_data_b;
      OP_OR:   alu_result = alu_data_a | alu_data_b;
      OP_ADD:  alu_result = alu_data_a + alu_data_b;
      OP_SUB:  alu_result = alu_data_a - alu_data_b;
      OP_SLT:  alu_result = ($signed(alu_data_a) < $signed(alu_data_b)) ? 32'd1 : 32'd0;
      OP_NOR:  alu_result = ~(alu_data_a | alu_data_b);
      default: alu_result = alu_data_a + alu_data_b;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    int          r;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[r*4 +: 4]  = op;
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
  endtask

  // one complete single-requester transaction, checking each phase
  task automatic run_op(input vec_t v);
    logic [1:0] oh;
    oh = (v.r == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    set_req(v.r, v.op, v.a, v.b);
    req_valid = oh;
    rsp_ready = 2'b00;
    #1 chk("idle_ready", {30'd0, req_ready}, {30'd0, oh});
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("exec_ready", {30'd0, req_ready}, 32'd0);
    chk("exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("exec_op", {28'd0, alu_operation}, {28'd0, v.op});
    chk("exec_a", alu_data_a, v.a);
    chk("exec_b", alu_data_b, v.b);
    @(negedge clk);
    #1;
    chk("resp_valid", {30'd0, rsp_valid}, {30'd0, oh});
    chk("resp_result", rsp_result, v.res);
    chk("resp_zero", {31'd0, rsp_zero}, {31'd0, v.z});
    rsp_ready = oh;
    @(negedge clk);
    #1 chk("after_resp_valid", {30'd0, rsp_valid}, 32'd0);
    rsp_ready = 2'b00;
    last_served = v.r;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_req_ready"}, {30'd0, req_ready}, 32'd0);
    chk({nm, "_rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
    chk({nm, "_alu_op"}, {28'd0, alu_operation}, 32'd0);
    chk({nm, "_alu_a"}, alu_data_a, 32'd0);
    chk({nm, "_alu_b"}, alu_data_b, 32'd0);
    chk({nm, "_rsp_result"}, rsp_result, 32'd0);
    chk({nm, "_rsp_zero"}, {31'd0, rsp_zero}, 32'd0);
  endtask

  initial begin
    int grants[6];
    int gcyc[6];
    int ng;

    vecs[0] = '{0, OP_ADD, 32'd5,        32'd3,        32'd8,        1'b0};
    vecs[1] = '{1, OP_SUB, 32'd7,        32'd7,        32'd0,        1'b1};
    vecs[2] = '{0, OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0};
    vecs[3] = '{1, OP_OR,  32'h1200_0000, 32'h0000_0034, 32'h1200_0034, 1'b0};
    vecs[4] = '{0, OP_SLT, 32'd5,        32'd3,        32'd0,        1'b1};
    vecs[5] = '{1, OP_SLT, 32'hFFFF_FFFE, 32'd2,        32'd1,        1'b0};
    vecs[6] = '{0, OP_NOR, 32'hFFFF_0000, 32'h0000_00FF, 32'h0000_FF00, 1'b0};
    vecs[7] = '{1, OP_ADD, 32'hFFFF_FFFF, 32'd1,        32'd0,        1'b1};
    vecs[8] = '{0, 4'b1111, 32'd2,       32'd3,        32'd5,        1'b0};

    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 chk_reset_outputs("reset");

    // both valid in the first cycle after reset: requester 0 goes first
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, OP_OR, 32'h0000_00F0, 32'h0000_000F);
    set_req(1, OP_NOR, 32'd0, 32'd0);
    req_valid = 2'b11;
    #1 chk("both_ready_first", {30'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b10;
    #1 chk("both_exec_op0", {28'd0, alu_operation}, {28'd0, OP_OR});
    @(negedge clk);
    #1;
    chk("both_rsp0_valid", {30'd0, rsp_valid}, 32'd1);
    chk("both_rsp0_result", rsp_result, 32'h0000_00FF);
    chk("both_rsp0_ready_held", {30'd0, req_ready}, 32'd0);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1 chk("both_ready_second", {30'd0, req_ready}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk("both_exec_op1", {28'd0, alu_operation}, {28'd0, OP_NOR});
    @(negedge clk);
    #1;
    chk("both_rsp1_valid", {30'd0, rsp_valid}, 32'd2);
    chk("both_rsp1_result", rsp_result, 32'hFFFF_FFFF);
    chk("both_rsp1_zero", {31'd0, rsp_zero}, 32'd0);
    rsp_ready = 2'b11;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1 chk("both_done", {30'd0, rsp_valid}, 32'd0);
    last_served = 1;

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // both held valid: grants alternate, one accept every 3 cycles
    @(negedge clk);
    set_req(0, OP_ADD, 32'd1, 32'd1);
    set_req(1, OP_SUB, 32'd9, 32'd4);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    ng = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (rsp_valid == 2'b01) chk("alt_result0", rsp_result, 32'd2);
      else if (rsp_valid == 2'b10) chk("alt_result1", rsp_result, 32'd5);
      else chk("alt_rsp_onehot", {30'd0, rsp_valid}, 32'd0);
      if (req_ready != 2'b00) begin
        grants[ng] = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : 2;
        gcyc[ng] = cyc;
        ng++;
      end
      if (ng == 6) break;
      @(negedge clk);
    end
    chk("alt_grant_count", ng, 6);
    if (ng == 6) begin
      chk("alt_first_grant", grants[0], 1 - last_served);
      for (int k = 1; k < 6; k++) begin
        chk("alt_grant_alternates", grants[k], 1 - grants[k-1]);
        chk("alt_grant_spacing", gcyc[k] - gcyc[k-1], 3);
      end
      last_served = grants[5];
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rsp_ready = 2'b00;
    #1 chk("alt_drained", {30'd0, rsp_valid}, 32'd0);

    // backpressure on an SLT response while requester 1 waits
    @(negedge clk);
    set_req(0, OP_SLT, 32'hFFFF_FFFF, 32'd1);
    set_req(1, OP_ADD, 32'd10, 32'd20);
    req_valid = 2'b01;
    #1 chk("bp_ready", {30'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b10;
    #1 chk("bp_exec_ready", {30'd0, req_ready}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp_valid", {30'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_result", rsp_result, 32'd1);
      chk("bp_rsp_zero", {31'd0, rsp_zero}, 32'd0);
      chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 2'b10;
    #1 chk("bp_nonowner_ignored", {30'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    #1 chk("bp_nonowner_still", {30'd0, rsp_valid}, 32'd1);
    rsp_ready = 2'b01;
    @(negedge clk);
    #1;
    chk("bp_released", {30'd0, rsp_valid}, 32'd0);
    chk("bp_next_ready", {30'd0, req_ready}, 32'd2);
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(negedge clk);
    #1;
    chk("bp_drop_idle", {30'd0, req_ready}, 32'd0);
    chk("bp_drop_no_latch", {28'd0, alu_operation}, {28'd0, OP_SLT});
    last_served = 0;

    // reset during EXEC discards the operation and restores req0 priority
    @(negedge clk);
    set_req(1, OP_ADD, 32'd4, 32'd4);
    req_valid = 2'b10;
    #1 chk("rst_ready", {30'd0, req_ready}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk("rst_exec_a", alu_data_a, 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    #1 chk_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rst_no_rsp", {30'd0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    set_req(0, OP_ADD, 32'd1, 32'd2);
    set_req(1, OP_ADD, 32'd4, 32'd4);
    req_valid = 2'b11;
    #1 chk("rst_req0_priority", {30'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("rst_after_valid", {30'd0, rsp_valid}, 32'd1);
    chk("rst_after_result", rsp_result, 32'd3);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1 chk("rst_after_done", {30'd0, rsp_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
